// File: rtl/multi_digit_7_segment_driver_pkg.sv
// rtl/multi_digit_7_segment_driver_pkg.sv - shared types and constants for the 7-segment driver
// Purpose: FSM state type, 16-entry active-high segment table and small helpers.
// Ports: none (package).
package multi_digit_7_segment_driver_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } state_t;

  // Active-high patterns, bit 6 = A ... bit 0 = G; entry i sits at [i*7 +: 7].
  localparam logic [16*7-1:0] SEG_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    return SEG_TABLE[int'(d)*7 +: 7];
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bin_to_bcd_serial.sv
// rtl/bin_to_bcd_serial.sv - serial shift-and-add-3 binary to BCD converter
// Purpose: converts DATA_WIDTH-bit binary to BCD_DIGITS packed BCD digits, one bit per clock.
// Ports:
//   i_Clk, i_Rst_L  clock, synchronous active-low reset
//   i_Start         start strobe, honoured only while o_Busy=0; captures i_Bin
//   i_Bin           binary operand
//   o_Busy          conversion in progress
//   o_Done          one-cycle pulse; o_Bcd is valid from this cycle until the next start
//   o_Bcd           packed BCD result, digit 0 in [3:0]
module bin_to_bcd_serial
  import multi_digit_7_segment_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BCD_DIGITS = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_Start,
  input  logic [DATA_WIDTH-1:0]   i_Bin,
  output logic                    o_Busy,
  output logic                    o_Done,
  output logic [BCD_DIGITS*4-1:0] o_Bcd
);

  localparam int BCD_W = BCD_DIGITS * 4;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]      r_bcd;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;

  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b, input logic s);
    logic [BCD_W-1:0] a;
    a = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (a[i*4 +: 4] >= 4'd5) a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
    end
    return {a[BCD_W-2:0], s};
  endfunction

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_bcd <= dd_step(r_bcd, r_bin[DATA_WIDTH-1]);
        r_bin <= {r_bin[DATA_WIDTH-2:0], 1'b0};
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (i_Start) begin
        // The first shift happens on the start edge: adjusting an all-zero
        // BCD register is a no-op, so the MSB simply lands in bit 0.
        r_bcd  <= BCD_W'(i_Bin[DATA_WIDTH-1]);
        r_bin  <= {i_Bin[DATA_WIDTH-2:0], 1'b0};
        r_cnt  <= CNT_W'(DATA_WIDTH - 1);
        r_busy <= 1'b1;
      end
    end
  end

  assign o_Busy = r_busy;
  assign o_Done = r_done;
  assign o_Bcd  = r_bcd;

endmodule

// File: rtl/multi_digit_7_segment_driver.sv
// rtl/multi_digit_7_segment_driver.sv - multiplexed multi-digit 7-segment display driver
// Purpose: converts a binary value (decimal via serial double dabble, or hex nibbles),
//          holds it in a display register and scans it out one digit per refresh step.
// Ports:
//   i_Clk, i_Rst_L  clock, synchronous active-low reset
//   i_Load          load strobe, accepted only while o_Ready=1
//   i_Value         unsigned value to display
//   i_Blank_Lz      blank leading zero digits (sampled live)
//   o_Ready         idle, a load is accepted this cycle
//   o_Segments      registered segment drive, bit 6 = A ... bit 0 = G
//   o_Digit_En      registered one-hot digit enable, bit 0 = least significant digit
//   o_Overflow      committed value had nonzero digits beyond NUM_DIGITS
module multi_digit_7_segment_driver
  import multi_digit_7_segment_driver_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_DIGITS     = 3,
  parameter int REFRESH_DIV    = 25000,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_Load,
  input  logic [DATA_WIDTH-1:0] i_Value,
  input  logic                  i_Blank_Lz,
  output logic                  o_Ready,
  output logic [6:0]            o_Segments,
  output logic [NUM_DIGITS-1:0] o_Digit_En,
  output logic                  o_Overflow
);

  localparam int BCD_DIGITS = (DATA_WIDTH + 2) / 3 + 1;
  localparam int BCD_W      = BCD_DIGITS * 4;
  localparam int ALL_DIGITS = max_int(BCD_DIGITS, NUM_DIGITS);
  localparam int ALL_W      = ALL_DIGITS * 4;
  localparam int REF_W      = $clog2(REFRESH_DIV);
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] EN_OFF  = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  state_t                  r_state;
  logic [NUM_DIGITS*4-1:0] r_disp;
  logic                    r_ovf;
  logic [REF_W-1:0]        r_refresh;
  logic [IDX_W-1:0]        r_idx;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_en;

  logic                    w_accept;
  logic                    w_start;
  logic                    w_busy;
  logic                    w_done;
  logic [BCD_W-1:0]        w_bcd;
  logic [ALL_W-1:0]        w_all;
  logic [NUM_DIGITS*4-1:0] w_disp_next;
  logic                    w_ovf_next;
  logic [NUM_DIGITS-1:0]   w_upper_zero;
  logic                    w_run_zero;
  logic [3:0]              w_cur;
  logic                    w_cur_lz;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [6:0]              w_pat;
  logic                    w_tc;

  assign o_Ready  = (r_state == ST_IDLE) && !w_busy;
  assign w_accept = i_Load && o_Ready;
  assign w_start  = w_accept && (HEX_MODE == 0);

  bin_to_bcd_serial #(
    .DATA_WIDTH (DATA_WIDTH),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bcd (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Start (w_start),
    .i_Bin   (i_Value),
    .o_Busy  (w_busy),
    .o_Done  (w_done),
    .o_Bcd   (w_bcd)
  );

  // Digits kept on the display vs. digits that only feed the overflow flag.
  always_comb begin
    w_all       = (HEX_MODE != 0) ? ALL_W'(i_Value) : ALL_W'(w_bcd);
    w_disp_next = '0;
    w_ovf_next  = 1'b0;
    for (int k = 0; k < ALL_DIGITS; k++) begin
      if (k < NUM_DIGITS) w_disp_next[k*4 +: 4] = w_all[k*4 +: 4];
      else                w_ovf_next = w_ovf_next | (|w_all[k*4 +: 4]);
    end
  end

  // w_upper_zero[k]: digits k..NUM_DIGITS-1 are all zero.
  always_comb begin
    w_upper_zero = '0;
    w_run_zero   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_run_zero      = w_run_zero & (r_disp[k*4 +: 4] == 4'd0);
      w_upper_zero[k] = w_run_zero;
    end
  end

  always_comb begin
    w_cur    = 4'd0;
    w_cur_lz = 1'b0;
    w_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_cur       = r_disp[k*4 +: 4];
        w_cur_lz    = (k != 0) && w_upper_zero[k];
        w_onehot[k] = 1'b1;
      end
    end
    w_pat = (i_Blank_Lz && w_cur_lz) ? 7'h00 : seg_encode(w_cur);
  end

  assign w_tc = (r_refresh == REF_W'(REFRESH_DIV - 1));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_state   <= ST_IDLE;
      r_disp    <= '0;
      r_ovf     <= 1'b0;
      r_refresh <= '0;
      r_idx     <= '0;
      r_seg     <= SEG_OFF;
      r_en      <= EN_OFF;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (HEX_MODE != 0) begin
              r_disp <= w_disp_next;
              r_ovf  <= w_ovf_next;
            end else begin
              r_state <= ST_CONVERT;
            end
          end
        end
        ST_CONVERT: begin
          if (w_done) begin
            r_disp  <= w_disp_next;
            r_ovf   <= w_ovf_next;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Pattern and enable load together so a digit never shows its neighbour's pattern.
      if (w_tc) begin
        r_refresh <= '0;
        r_seg     <= (SEG_ACTIVE_LOW != 0) ? ~w_pat : w_pat;
        r_en      <= (SEG_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
        r_idx     <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_refresh <= r_refresh + REF_W'(1);
      end
    end
  end

  assign o_Segments = r_seg;
  assign o_Digit_En = r_en;
  assign o_Overflow = r_ovf;

endmodule

// File: tb/tb_multi_digit_7_segment_driver.sv
// tb/tb_multi_digit_7_segment_driver.sv - self-checking bench for multi_digit_7_segment_driver
module tb_multi_digit_7_segment_driver;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [7:0] value;
  logic       blank;
  logic       load_a, load_b, load_h;
  logic       ready_a, ready_b, ready_h;
  logic       ovf_a, ovf_b, ovf_h;
  logic [6:0] seg_a, seg_b, seg_h;
  logic [2:0] en_a, en_h;
  logic [1:0] en_b;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [6:0] s0, s1, s2; logic ovf; } exp_t;
  typedef struct { logic [7:0] value; logic blank; logic [6:0] s0, s1, s2; } vec_t;

  exp_t q_exp[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  multi_digit_7_segment_driver #(.DATA_WIDTH(8), .NUM_DIGITS(3), .REFRESH_DIV(4),
    .HEX_MODE(0), .SEG_ACTIVE_LOW(1)) u_dut_a (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Load(load_a), .i_Value(value), .i_Blank_Lz(blank),
    .o_Ready(ready_a), .o_Segments(seg_a), .o_Digit_En(en_a), .o_Overflow(ovf_a));

  multi_digit_7_segment_driver #(.DATA_WIDTH(8), .NUM_DIGITS(2), .REFRESH_DIV(4),
    .HEX_MODE(0), .SEG_ACTIVE_LOW(1)) u_dut_b (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Load(load_b), .i_Value(value), .i_Blank_Lz(blank),
    .o_Ready(ready_b), .o_Segments(seg_b), .o_Digit_En(en_b), .o_Overflow(ovf_b));

  multi_digit_7_segment_driver #(.DATA_WIDTH(8), .NUM_DIGITS(3), .REFRESH_DIV(4),
    .HEX_MODE(1), .SEG_ACTIVE_LOW(0)) u_dut_h (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Load(load_h), .i_Value(value), .i_Blank_Lz(blank),
    .o_Ready(ready_h), .o_Segments(seg_h), .o_Digit_En(en_h), .o_Overflow(ovf_h));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic get_ready(input int which, output logic r);
    case (which)
      0:       r = ready_a;
      1:       r = ready_b;
      default: r = ready_h;
    endcase
  endtask

  task automatic get_ovf(input int which, output logic o);
    case (which)
      0:       o = ovf_a;
      1:       o = ovf_b;
      default: o = ovf_h;
    endcase
  endtask

  task automatic do_load(input int which, input logic [7:0] v, input exp_t e);
    logic r;
    int n;
    n = 0;
    get_ready(which, r);
    while (r !== 1'b1 && n < 40) begin
      tick();
      n++;
      get_ready(which, r);
    end
    check("ready_before_load", r, 1);
    value = v;
    case (which)
      0:       load_a = 1'b1;
      1:       load_b = 1'b1;
      default: load_h = 1'b1;
    endcase
    q_exp.push_back(e);
    tick();
    load_a = 1'b0;
    load_b = 1'b0;
    load_h = 1'b0;
  endtask

  // Returns the cycle index (acceptance edge = cycle 0) at which o_Ready is seen high.
  task automatic wait_ready(input int which, input int start, output int n);
    logic r;
    n = start;
    get_ready(which, r);
    while (r !== 1'b1 && n < 40) begin
      tick();
      n++;
      get_ready(which, r);
    end
  endtask

  task automatic read_disp(input int which, output logic [6:0] d0, output logic [6:0] d1,
                           output logic [6:0] d2);
    logic [2:0] en;
    logic [6:0] s;
    int badhot;
    badhot = 0;
    d0 = 'x;
    d1 = 'x;
    d2 = 'x;
    for (int c = 0; c < 30; c++) begin
      tick();
      case (which)
        0:       begin en = ~en_a;           s = seg_a; end
        1:       begin en = {1'b0, ~en_b};   s = seg_b; end
        default: begin en = en_h;            s = seg_h; end
      endcase
      case (en)
        3'b001:  d0 = s;
        3'b010:  d1 = s;
        3'b100:  d2 = s;
        default: badhot++;
      endcase
    end
    check("digit_en_onehot", badhot, 0);
  endtask

  task automatic check_disp(input int which, input string name, input int ndig);
    exp_t e;
    logic [6:0] d0, d1, d2;
    logic ov;
    if (q_exp.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = q_exp.pop_front();
      read_disp(which, d0, d1, d2);
      check({name, "_d0"}, d0, e.s0);
      if (ndig > 1) check({name, "_d1"}, d1, e.s1);
      if (ndig > 2) check({name, "_d2"}, d2, e.s2);
      get_ovf(which, ov);
      check({name, "_ovf"}, ov, e.ovf);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_l  = 1'b0;
    value  = 8'd0;
    blank  = 1'b0;
    load_a = 1'b0;
    load_b = 1'b0;
    load_h = 1'b0;

    // Active-low patterns: 0=01 1=4F 2=12 3=06 4=4C 5=24 6=20 7=0F 8=00 9=04, off=7F
    vecs[0] = '{8'd123, 1'b0, 7'h06, 7'h12, 7'h4F};
    vecs[1] = '{8'd7,   1'b1, 7'h0F, 7'h7F, 7'h7F};
    vecs[2] = '{8'd0,   1'b1, 7'h01, 7'h7F, 7'h7F};
    vecs[3] = '{8'd255, 1'b0, 7'h24, 7'h24, 7'h12};
    vecs[4] = '{8'd105, 1'b1, 7'h24, 7'h01, 7'h4F};
    vecs[5] = '{8'd40,  1'b1, 7'h01, 7'h4C, 7'h7F};
    vecs[6] = '{8'd98,  1'b0, 7'h00, 7'h04, 7'h01};
    vecs[7] = '{8'd61,  1'b0, 7'h4F, 7'h20, 7'h01};

    repeat (3) tick();
    check("rst_ready",  ready_a, 1);
    check("rst_seg",    seg_a,   7'h7F);
    check("rst_en",     en_a,    3'b111);
    check("rst_ovf",    ovf_a,   0);
    check("rst_en_b",   en_b,    2'b11);
    check("rst_seg_h",  seg_h,   7'h00);
    check("rst_en_h",   en_h,    3'b000);
    rst_l = 1'b1;

    for (int i = 0; i < 8; i++) begin
      blank = vecs[i].blank;
      do_load(0, vecs[i].value, '{vecs[i].s0, vecs[i].s1, vecs[i].s2, 1'b0});
      wait_ready(0, 1, n);
      check("dec_latency", n, 9);
      check_disp(0, "vec", 3);
    end

    // Leading-zero blanking follows i_Blank_Lz live.
    blank = 1'b1;
    do_load(0, 8'd7, '{7'h0F, 7'h7F, 7'h7F, 1'b0});
    wait_ready(0, 1, n);
    check_disp(0, "lz_on", 3);
    blank = 1'b0;
    q_exp.push_back('{7'h0F, 7'h01, 7'h01, 1'b0});
    check_disp(0, "lz_off", 3);

    // Load during conversion is ignored.
    do_load(0, 8'd200, '{7'h01, 7'h01, 7'h12, 1'b0});
    tick();
    tick();
    value  = 8'd50;
    load_a = 1'b1;
    tick();
    load_a = 1'b0;
    wait_ready(0, 4, n);
    check("busy_load_latency", n, 9);
    check_disp(0, "busy_load", 3);

    // Two-digit instance: overflow set and held until the next commit.
    do_load(1, 8'd255, '{7'h24, 7'h24, 7'h00, 1'b1});
    repeat (7) tick();
    check("b255_ready_c8", ready_b, 0);
    check("b255_ovf_c8",   ovf_b,   0);
    tick();
    check("b255_ready_c9", ready_b, 1);
    check("b255_ovf_c9",   ovf_b,   1);
    check_disp(1, "b255", 2);
    do_load(1, 8'd42, '{7'h12, 7'h4C, 7'h00, 1'b0});
    repeat (7) tick();
    check("b42_ovf_c8", ovf_b, 1);
    tick();
    check("b42_ovf_c9", ovf_b, 0);
    check_disp(1, "b42", 2);

    // Hex, active-high: commit without a conversion phase.
    do_load(2, 8'hAF, '{7'h47, 7'h77, 7'h7E, 1'b0});
    wait_ready(2, 1, n);
    check("hex_latency", n, 1);
    check_disp(2, "hexAF", 3);
    blank = 1'b1;
    do_load(2, 8'h05, '{7'h5B, 7'h00, 7'h00, 1'b0});
    check_disp(2, "hex05_lz", 3);
    blank = 1'b0;

    // Reset in the middle of a conversion aborts it.
    value  = 8'd99;
    load_a = 1'b1;
    tick();
    load_a = 1'b0;
    repeat (3) tick();
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    check("abort_ready", ready_a, 1);
    check("abort_seg",   seg_a,   7'h7F);
    check("abort_en",    en_a,    3'b111);
    check("abort_ovf",   ovf_a,   0);
    n = 0;
    while (en_a === 3'b111 && n < 20) begin
      n++;
      tick();
    end
    check("abort_first_drive", n, 4);
    check("abort_first_en",    en_a,  3'b110);
    check("abort_first_seg",   seg_a, 7'h01);
    q_exp.push_back('{7'h01, 7'h01, 7'h01, 1'b0});
    check_disp(0, "abort", 3);
    check("abort_ready_end", ready_a, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_digit_7_segment_driver.md
MULTI_DIGIT_7_SEGMENT_DRIVER -- requirements
Module: multi_digit_7_segment_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, binary input width, legal range 4..16.
REQ-002 SHALL have parameter NUM_DIGITS, default 3, number of multiplexed digits, legal range 1..8.
REQ-003 SHALL have parameter REFRESH_DIV, default 25000, clocks each digit is driven per scan step, legal minimum 2.
REQ-004 SHALL have parameter HEX_MODE, default 0: 0 = decimal display, 1 = hexadecimal display.
REQ-005 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 = segment and digit-enable outputs active-low, 0 = active-high.
REQ-006 i_Clk  input  1  single system clock; all logic on rising edge.
REQ-007 i_Rst_L  input  1  reset, synchronous, active-low.
REQ-008 i_Load  input  1  load strobe; accepted only when o_Ready=1.
REQ-009 i_Value  input  DATA_WIDTH  unsigned binary value to display.
REQ-010 i_Blank_Lz  input  1  1 = blank leading zero digits.
REQ-011 o_Ready  output  1  converter idle; a load is accepted this cycle.
REQ-012 o_Segments  output  7  segment drive, bit 6 = A ... bit 0 = G, registered.
REQ-013 o_Digit_En  output  NUM_DIGITS  one-hot digit enable, bit 0 = least significant digit, registered.
REQ-014 o_Overflow  output  1  committed value has nonzero digits beyond NUM_DIGITS.

Function
REQ-015 FSM SHALL have states IDLE and CONVERT; IDLE->CONVERT on i_Load&&o_Ready; o_Ready=1 only in IDLE.
REQ-016 In decimal mode CONVERT SHALL run shift-and-add-3 (double dabble), one bit per cycle, DATA_WIDTH cycles; the internal BCD register SHALL hold ceil(DATA_WIDTH/3)+1 digits.
REQ-017 The display register and o_Overflow SHALL update DATA_WIDTH+1 cycles after load acceptance, in the same cycle the FSM returns to IDLE; o_Ready SHALL be 1 in that cycle.
REQ-018 In hex mode the value SHALL be split into nibbles and committed 1 cycle after acceptance, without entering CONVERT.
REQ-019 i_Load while o_Ready=0 SHALL be ignored; the captured operand SHALL not change during CONVERT.
REQ-020 The display SHALL show the previously committed value until commit; no partial results are visible.
REQ-021 Digits above NUM_DIGITS SHALL be dropped; o_Overflow=1 iff any dropped digit is nonzero; o_Overflow SHALL hold until the next commit.
REQ-022 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count the digit index SHALL advance 0,1,...,NUM_DIGITS-1,0.
REQ-023 o_Segments and o_Digit_En SHALL update in the same clock edge, with no cycle showing a new digit's enable with the old digit's pattern.
REQ-024 Active-high encodings SHALL be: 0=7E,1=30,2=6D,3=79,4=33,5=5B,6=5F,7=70,8=7F,9=7B,A=77,b=1F,C=4E,d=3D,E=4F,F=47; with SEG_ACTIVE_LOW=1 both outputs SHALL be bitwise inverted.
REQ-025 If i_Blank_Lz=1, digit k>0 SHALL be blanked (all segments off) when digits k..NUM_DIGITS-1 are all zero; digit 0 SHALL never be blanked. i_Blank_Lz SHALL be sampled live, not at load.

Reset
REQ-026 When i_Rst_L=0 at a rising edge: FSM=IDLE, o_Ready=1, display digits=0, o_Overflow=0, refresh counter=0, digit index=0, o_Segments all off, o_Digit_En all disabled.
REQ-027 Reset during CONVERT SHALL abort conversion; no commit of the aborted value SHALL occur.
REQ-028 The first digit drive after reset SHALL occur at the first refresh terminal count.

Structure
REQ-029 A shared package SHALL hold the 16-entry segment encoding constant and the FSM state typedef.
REQ-030 The double-dabble converter SHALL be a sub-module bin_to_bcd_serial with start/busy/done handshake; scan, blanking and encoding stay in the top module.

Verification (DATA_WIDTH=8, NUM_DIGITS=3, REFRESH_DIV=4, SEG_ACTIVE_LOW=1 unless stated)
REQ-031 Load 123 -> o_Ready low for 8 cycles, commit at cycle 9; scan yields digit0=06, digit1=12, digit2=4F, o_Overflow=0.
REQ-032 i_Blank_Lz=1, load 7 -> digit0=0F, digit1 and digit2=7F (off); set i_Blank_Lz=0 -> digits 1,2 show 01 (zero).
REQ-033 NUM_DIGITS=2, load 255 -> display "55", o_Overflow=1; then load 42 -> display "42", o_Overflow=0.
REQ-034 Load 200, pulse i_Load with 50 three cycles later -> 50 ignored, display 200 after commit.
REQ-035 Load 99, assert i_Rst_L=0 at cycle 4 of CONVERT -> o_Ready=1, display 0, outputs off until first refresh terminal count.
REQ-036 HEX_MODE=1, SEG_ACTIVE_LOW=0, load 8'hAF -> commit after 1 cycle; digit0=47, digit1=77, digit2=7E; o_Digit_En one-hot active-high.
